// File: rtl/local_ni_pkg.sv
// Shared types for the local network interface: extended flit, FSM states, and helpers.
package local_ni_pkg;

   typedef struct packed {
      logic        vld;
      logic        golden;
      logic [1:0]  dst_y;
      logic [1:0]  dst_x;
      logic [31:0] data;
   } flit_ext_t;

   localparam int WIDTH_FLIT_EXT = $bits(flit_ext_t);

   typedef enum logic [1:0] {IDLE, OFFER, WAIT, CHECK} local_ni_state_t;

   function automatic flit_ext_t with_vld(input flit_ext_t f);
      flit_ext_t r;
      r     = f;
      r.vld = 1'b1;
      return r;
   endfunction

   function automatic logic [15:0] sat_add16(input logic [15:0] a, input logic [1:0] b);
      logic [16:0] s;
      s = {1'b0, a} + {15'd0, b};
      return s[16] ? 16'hFFFF : s[15:0];
   endfunction

endpackage

// File: rtl/local_ni_if.sv
// Core/router-facing signal bundle of local_ni; slave is the NI side, master the environment.
interface local_ni_if;
   import local_ni_pkg::*;

   flit_ext_t   core_inj_flit;
   logic        core_inj_vld;
   logic        core_inj_rdy;
   flit_ext_t   rtr_din_l;
   logic        local_inject_gnt;
   flit_ext_t   dout_l_1;
   flit_ext_t   dout_l_2;
   flit_ext_t   core_ej_flit;
   logic        core_ej_vld;
   logic        core_ej_rdy;
   logic        ej_overflow;
   logic [15:0] stat_inj_retry;
   logic [15:0] stat_ej_drop;

   modport slave (
      input  core_inj_flit, core_inj_vld, local_inject_gnt, dout_l_1, dout_l_2, core_ej_rdy,
      output core_inj_rdy, rtr_din_l, core_ej_flit, core_ej_vld, ej_overflow,
             stat_inj_retry, stat_ej_drop
   );

   modport master (
      output core_inj_flit, core_inj_vld, local_inject_gnt, dout_l_1, dout_l_2, core_ej_rdy,
      input  core_inj_rdy, rtr_din_l, core_ej_flit, core_ej_vld, ej_overflow,
             stat_inj_retry, stat_ej_drop
   );

endinterface

// File: rtl/local_ni_fifo_2w1r.sv
// Two-write (ordered, as many as fit) / one-read FIFO; stored flits always carry vld=1.
module ni_fifo_2w1r
   import local_ni_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                       clk,
   input  logic                       n_rst,
   input  logic                       wr1_en_i,
   input  flit_ext_t                  wr1_data_i,
   input  logic                       wr2_en_i,
   input  flit_ext_t                  wr2_data_i,
   input  logic                       rd_en_i,
   output flit_ext_t                  rd_data_o,
   output flit_ext_t                  rd_data_nxt_o,
   output logic [$clog2(DEPTH):0]     count_o,
   output logic [$clog2(DEPTH):0]     count_nxt_o,
   output logic                       empty_o,
   output logic                       wr1_ok_o,
   output logic                       wr2_ok_o
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

   flit_ext_t         mem_q [DEPTH];
   logic [AW-1:0]     wr_ptr_q;
   logic [AW-1:0]     rd_ptr_q;
   logic [CW-1:0]     count_q;
   logic [CW-1:0]     count_d;
   logic [CW-1:0]     free;
   logic [CW-1:0]     free_after1;
   logic [AW-1:0]     wr2_ptr;
   logic [1:0]        n_wr;
   logic              pop;

   // Space is judged on the registered count, so a same-cycle pop never makes room.
   always_comb begin
      free        = DEPTH_C - count_q;
      wr1_ok_o    = wr1_en_i && (free != '0);
      free_after1 = wr1_ok_o ? free - CW'(1) : free;
      wr2_ok_o    = wr2_en_i && (free_after1 != '0);
      wr2_ptr     = wr_ptr_q + AW'(wr1_ok_o);
      n_wr        = {1'b0, wr1_ok_o} + {1'b0, wr2_ok_o};
      pop         = rd_en_i && (count_q != '0);
      count_d     = count_q + CW'(n_wr) - CW'(pop);
   end

   always_ff @(posedge clk) begin
      if (wr1_ok_o) mem_q[wr_ptr_q] <= with_vld(wr1_data_i);
      if (wr2_ok_o) mem_q[wr2_ptr]  <= with_vld(wr2_data_i);
   end

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_q + AW'(n_wr);
         rd_ptr_q <= rd_ptr_q + AW'(pop);
         count_q  <= count_d;
      end
   end

   assign empty_o       = (count_q == '0);
   assign rd_data_o     = empty_o ? '0 : mem_q[rd_ptr_q];
   assign rd_data_nxt_o = mem_q[rd_ptr_q + AW'(1)];
   assign count_o       = count_q;
   assign count_nxt_o   = count_d;

endmodule

// File: rtl/local_ni.sv
// Local NI between core and router local port: offer/wait/check injection with retry, dual-port ejection queue.
// Optional statistics counters are built when LOCAL_NI_STATS_EN is defined.
module local_ni
   import local_ni_pkg::*;
#(
   parameter int INJ_DEPTH   = 4,
   parameter int EJ_DEPTH    = 8,
   parameter int GNT_LATENCY = 2
) (
   input  logic       clk,
   input  logic       n_rst,
   local_ni_if.slave  bus
);
   localparam int INJ_CW = $clog2(INJ_DEPTH) + 1;
   localparam int EJ_CW  = $clog2(EJ_DEPTH) + 1;
   localparam int WCW    = $clog2(GNT_LATENCY);

   local_ni_state_t     state_q;
   flit_ext_t           rtr_din_l_q;
   logic [WCW-1:0]      wait_cnt_q;
   logic                inj_rdy_q;
   logic                ej_overflow_q;

   flit_ext_t           inj_head;
   flit_ext_t           inj_head_nxt;
   logic [INJ_CW-1:0]   inj_count;
   logic [INJ_CW-1:0]   inj_count_nxt;
   logic                inj_empty;
   logic                inj_wr1_ok;
   logic                inj_wr2_ok;
   logic                inj_pop;

   flit_ext_t           ej_head;
   flit_ext_t           ej_head_nxt;
   logic [EJ_CW-1:0]    ej_count;
   logic [EJ_CW-1:0]    ej_count_nxt;
   logic                ej_empty;
   logic                ej_wr1_ok;
   logic                ej_wr2_ok;
   logic [1:0]          ej_drop_n;

   logic                inj_unused;
   logic                ej_unused;

   assign inj_pop = (state_q == CHECK) && bus.local_inject_gnt;

   ni_fifo_2w1r #(.DEPTH(INJ_DEPTH)) u_inj_fifo (
      .clk           (clk),
      .n_rst         (n_rst),
      .wr1_en_i      (bus.core_inj_vld && inj_rdy_q),
      .wr1_data_i    (bus.core_inj_flit),
      .wr2_en_i      (1'b0),
      .wr2_data_i    ('0),
      .rd_en_i       (inj_pop),
      .rd_data_o     (inj_head),
      .rd_data_nxt_o (inj_head_nxt),
      .count_o       (inj_count),
      .count_nxt_o   (inj_count_nxt),
      .empty_o       (inj_empty),
      .wr1_ok_o      (inj_wr1_ok),
      .wr2_ok_o      (inj_wr2_ok)
   );

   ni_fifo_2w1r #(.DEPTH(EJ_DEPTH)) u_ej_fifo (
      .clk           (clk),
      .n_rst         (n_rst),
      .wr1_en_i      (bus.dout_l_1.vld),
      .wr1_data_i    (bus.dout_l_1),
      .wr2_en_i      (bus.dout_l_2.vld),
      .wr2_data_i    (bus.dout_l_2),
      .rd_en_i       (bus.core_ej_rdy),
      .rd_data_o     (ej_head),
      .rd_data_nxt_o (ej_head_nxt),
      .count_o       (ej_count),
      .count_nxt_o   (ej_count_nxt),
      .empty_o       (ej_empty),
      .wr1_ok_o      (ej_wr1_ok),
      .wr2_ok_o      (ej_wr2_ok)
   );

   assign inj_unused = ^{inj_wr1_ok, inj_wr2_ok};
   assign ej_unused  = ^{ej_head_nxt, ej_count, ej_count_nxt};
   assign ej_drop_n  = {1'b0, bus.dout_l_1.vld & ~ej_wr1_ok} + {1'b0, bus.dout_l_2.vld & ~ej_wr2_ok};

   // The offer register is loaded on the edge entering OFFER; after a granted pop the next head is the second entry.
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         state_q       <= IDLE;
         rtr_din_l_q   <= '0;
         wait_cnt_q    <= '0;
         inj_rdy_q     <= 1'b0;
         ej_overflow_q <= 1'b0;
      end else begin
         rtr_din_l_q   <= '0;
         inj_rdy_q     <= (inj_count_nxt != INJ_CW'(INJ_DEPTH));
         ej_overflow_q <= ej_overflow_q | (ej_drop_n != 2'd0);
         case (state_q)
            IDLE: begin
               if (!inj_empty) begin
                  state_q     <= OFFER;
                  rtr_din_l_q <= with_vld(inj_head);
               end
            end
            OFFER: begin
               state_q    <= WAIT;
               wait_cnt_q <= WCW'(GNT_LATENCY - 2);
            end
            WAIT: begin
               if (wait_cnt_q == '0) state_q <= CHECK;
               else                  wait_cnt_q <= wait_cnt_q - WCW'(1);
            end
            CHECK: begin
               if (bus.local_inject_gnt) begin
                  if (inj_count > INJ_CW'(1)) begin
                     state_q     <= OFFER;
                     rtr_din_l_q <= with_vld(inj_head_nxt);
                  end else begin
                     state_q <= IDLE;
                  end
               end else begin
                  state_q     <= OFFER;
                  rtr_din_l_q <= with_vld(inj_head);
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

`ifdef LOCAL_NI_STATS_EN
   logic [15:0] stat_retry_q;
   logic [15:0] stat_drop_q;

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         stat_retry_q <= '0;
         stat_drop_q  <= '0;
      end else begin
         stat_retry_q <= sat_add16(stat_retry_q, {1'b0, (state_q == CHECK) && !bus.local_inject_gnt});
         stat_drop_q  <= sat_add16(stat_drop_q, ej_drop_n);
      end
   end

   assign bus.stat_inj_retry = stat_retry_q;
   assign bus.stat_ej_drop   = stat_drop_q;
`else
   assign bus.stat_inj_retry = '0;
   assign bus.stat_ej_drop   = '0;
`endif

   assign bus.core_inj_rdy = inj_rdy_q;
   assign bus.rtr_din_l    = rtr_din_l_q;
   assign bus.core_ej_flit = ej_head;
   assign bus.core_ej_vld  = !ej_empty;
   assign bus.ej_overflow  = ej_overflow_q;

   // A grant outside CHECK means the router and NI disagree on grant latency.
   gnt_only_in_check: assert property (@(posedge clk) disable iff (!n_rst)
      bus.local_inject_gnt |-> (state_q == CHECK));

endmodule

// File: tb/tb_local_ni.sv
// Randomized bench for local_ni against a queue-based model, plus directed timing/overflow/reset scenarios.
module tb_local_ni;
   import local_ni_pkg::*;

   localparam int INJ_D = 4;
   localparam int EJ_D  = 8;
   localparam int L     = 2;

   logic clk   = 1'b0;
   logic n_rst = 1'b0;
   always #5 clk = ~clk;

   local_ni_if ni_bus();

   local_ni #(.INJ_DEPTH(INJ_D), .EJ_DEPTH(EJ_D), .GNT_LATENCY(L)) dut (
      .clk   (clk),
      .n_rst (n_rst),
      .bus   (ni_bus)
   );

   int n_vec = 0;
   int n_err = 0;
   int cyc   = 0;

   // Model: queue contents plus a timer since the last offer (-1 when idle).
   flit_ext_t m_inj_q[$];
   flit_ext_t m_ej_q[$];
   int        m_p     = -1;
   bit        m_rdy   = 0;
   bit        m_ovf   = 0;
   int        m_retry = 0;
   int        m_drop  = 0;

   // Router model: grant returned L cycles after each offer.
   bit        pend        = 0;
   bit        acc_val     = 0;
   int        due         = 0;
   bit        gnt_drv     = 0;
   int        accept_mode = 1;

   int        offer_cyc[$];
   flit_ext_t offer_flit[$];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic flit_ext_t rand_flit();
      flit_ext_t f;
      f.vld    = 1'($urandom);
      f.golden = 1'($urandom);
      f.dst_y  = 2'($urandom);
      f.dst_x  = 2'($urandom);
      f.data   = $urandom;
      return f;
   endfunction

   function automatic bit decide();
      if (accept_mode == 1) return 1'b1;
      if (accept_mode == 0) begin
         accept_mode = 1;
         return 1'b0;
      end
      return ($urandom_range(0, 99) < 70);
   endfunction

   task automatic model_reset();
      m_inj_q.delete();
      m_ej_q.delete();
      m_p     = -1;
      m_rdy   = 0;
      m_ovf   = 0;
      m_retry = 0;
      m_drop  = 0;
      pend    = 0;
      gnt_drv = 0;
   endtask

   task automatic ej_write(input flit_ext_t f, inout int free);
      if (free > 0) begin
         m_ej_q.push_back(with_vld(f));
         free--;
      end else begin
         m_ovf = 1;
         if (m_drop < 65535) m_drop++;
      end
   endtask

   task automatic model_edge();
      int free;
      if (!n_rst) begin
         model_reset();
         return;
      end
      if (m_p < 0) begin
         if (m_inj_q.size() > 0) m_p = 0;
      end else if (m_p < L) begin
         m_p++;
      end else if (gnt_drv) begin
         m_p = (m_inj_q.size() > 1) ? 0 : -1;
         void'(m_inj_q.pop_front());
      end else begin
         m_p = 0;
         if (m_retry < 65535) m_retry++;
      end
      if (ni_bus.core_inj_vld && m_rdy) m_inj_q.push_back(with_vld(ni_bus.core_inj_flit));
      m_rdy = (m_inj_q.size() < INJ_D);
      free = EJ_D - m_ej_q.size();
      if (ni_bus.core_ej_rdy && m_ej_q.size() > 0) void'(m_ej_q.pop_front());
      if (ni_bus.dout_l_1.vld) ej_write(ni_bus.dout_l_1, free);
      if (ni_bus.dout_l_2.vld) ej_write(ni_bus.dout_l_2, free);
   endtask

   task automatic compare_outputs();
      int exp_retry;
      int exp_drop;
`ifdef LOCAL_NI_STATS_EN
      exp_retry = m_retry;
      exp_drop  = m_drop;
`else
      exp_retry = 0;
      exp_drop  = 0;
`endif
      check("inj_rdy", 64'(ni_bus.core_inj_rdy), 64'(m_rdy));
      check("din_vld", 64'(ni_bus.rtr_din_l.vld), 64'(m_p == 0));
      if (m_p == 0 && m_inj_q.size() > 0) check("din_flit", 64'(ni_bus.rtr_din_l), 64'(m_inj_q[0]));
      check("ej_vld", 64'(ni_bus.core_ej_vld), 64'(m_ej_q.size() > 0));
      if (m_ej_q.size() > 0) check("ej_flit", 64'(ni_bus.core_ej_flit), 64'(m_ej_q[0]));
      check("ej_ovf", 64'(ni_bus.ej_overflow), 64'(m_ovf));
      check("stat_retry", 64'(ni_bus.stat_inj_retry), 64'(exp_retry));
      check("stat_drop", 64'(ni_bus.stat_ej_drop), 64'(exp_drop));
   endtask

   task automatic step();
      @(posedge clk);
      model_edge();
      cyc++;
      #1;
      compare_outputs();
      if (m_p == 0) begin
         offer_cyc.push_back(cyc);
         offer_flit.push_back(ni_bus.rtr_din_l);
      end
      gnt_drv = 0;
      if (pend) begin
         due--;
         if (due == 0) begin
            gnt_drv = acc_val;
            pend    = 0;
         end
      end
      if (m_p == 0) begin
         pend    = 1;
         due     = L;
         acc_val = decide();
      end
      ni_bus.local_inject_gnt = gnt_drv;
   endtask

   task automatic idle_inputs();
      ni_bus.core_inj_vld   = 0;
      ni_bus.dout_l_1       = '0;
      ni_bus.dout_l_2       = '0;
      ni_bus.core_ej_rdy    = 0;
   endtask

   task automatic do_reset_mid();
      n_rst = 0;
      #1;
      check("rst_din", 64'(ni_bus.rtr_din_l), 64'd0);
      check("rst_rdy", 64'(ni_bus.core_inj_rdy), 64'd0);
      check("rst_ej_vld", 64'(ni_bus.core_ej_vld), 64'd0);
      check("rst_ej_flit", 64'(ni_bus.core_ej_flit), 64'd0);
      check("rst_ovf", 64'(ni_bus.ej_overflow), 64'd0);
      check("rst_stats", 64'({ni_bus.stat_inj_retry, ni_bus.stat_ej_drop}), 64'd0);
      model_reset();
      ni_bus.local_inject_gnt = 0;
      idle_inputs();
      step();
      step();
      n_rst = 1;
   endtask

   initial begin
      flit_ext_t f;
      flit_ext_t t3_f[5];
      flit_ext_t exp_seq[8];
      flit_ext_t popped[$];
      int        c0;
      int        pushed;
      int        first_low;
      int        stat_before;
      bit        did;

      ni_bus.core_inj_flit    = '0;
      ni_bus.local_inject_gnt = 0;
      idle_inputs();

      // Reset and release
      step();
      step();
      check("reset_rdy", 64'(ni_bus.core_inj_rdy), 64'd0);
      check("reset_din_vld", 64'(ni_bus.rtr_din_l.vld), 64'd0);
      n_rst = 1;
      step();
      check("rdy_after_rst", 64'(ni_bus.core_inj_rdy), 64'd1);

      // T1: single flit dst(1,2), granted at first check
      f = rand_flit();
      f.dst_x = 2'd1;
      f.dst_y = 2'd2;
      f.vld   = 1'b0;
      ni_bus.core_inj_flit = f;
      ni_bus.core_inj_vld  = 1;
      offer_cyc.delete();
      offer_flit.delete();
      step();
      c0 = cyc;
      ni_bus.core_inj_vld = 0;
      for (int k = 0; k < 8; k++) step();
      check("t1_offers", 64'(offer_cyc.size()), 64'd1);
      if (offer_cyc.size() > 0) begin
         check("t1_offer_cycle", 64'(offer_cyc[0] - c0), 64'd1);
         check("t1_dst_x", 64'(offer_flit[0].dst_x), 64'd1);
         check("t1_dst_y", 64'(offer_flit[0].dst_y), 64'd2);
         check("t1_data", 64'(offer_flit[0].data), 64'(f.data));
      end

      // T2: first check rejected, second granted
      accept_mode = 0;
      stat_before = int'(ni_bus.stat_inj_retry);
      offer_cyc.delete();
      offer_flit.delete();
      ni_bus.core_inj_vld = 1;
      step();
      ni_bus.core_inj_vld = 0;
      for (int k = 0; k < 12; k++) step();
      check("t2_offers", 64'(offer_cyc.size()), 64'd2);
      if (offer_cyc.size() > 1) check("t2_spacing", 64'(offer_cyc[1] - offer_cyc[0]), 64'd3);
`ifdef LOCAL_NI_STATS_EN
      check("t2_retry", 64'(int'(ni_bus.stat_inj_retry) - stat_before), 64'd1);
`endif

      // T3: five pushes into a 4-deep queue, grant always
      accept_mode = 1;
      offer_cyc.delete();
      offer_flit.delete();
      pushed    = 0;
      first_low = -1;
      for (int i = 0; i < 5; i++) t3_f[i] = rand_flit();
      for (int k = 0; k < 40; k++) begin
         if (pushed < 5) begin
            ni_bus.core_inj_flit = t3_f[pushed];
            ni_bus.core_inj_vld  = 1;
         end else begin
            ni_bus.core_inj_vld = 0;
         end
         did = ni_bus.core_inj_vld && ni_bus.core_inj_rdy;
         step();
         if (did) pushed++;
         if (!ni_bus.core_inj_rdy && first_low < 0) first_low = pushed;
      end
      ni_bus.core_inj_vld = 0;
      check("t3_rdy_low_after", 64'(first_low), 64'd4);
      check("t3_offers", 64'(offer_cyc.size()), 64'd5);
      for (int i = 0; i < offer_cyc.size() && i < 5; i++) begin
         check("t3_order", 64'(offer_flit[i].data), 64'(t3_f[i].data));
         if (i > 0) check("t3_spacing", 64'(offer_cyc[i] - offer_cyc[i-1]), 64'd3);
      end

      // T4: both eject ports valid for 4 cycles, no pops
      for (int k = 0; k < 4; k++) begin
         ni_bus.dout_l_1 = with_vld(rand_flit());
         ni_bus.dout_l_2 = with_vld(rand_flit());
         exp_seq[2*k]    = ni_bus.dout_l_1;
         exp_seq[2*k+1]  = ni_bus.dout_l_2;
         step();
      end
      ni_bus.dout_l_1 = '0;
      ni_bus.dout_l_2 = '0;
      step();
      check("t4_no_ovf", 64'(ni_bus.ej_overflow), 64'd0);
      check("t4_head", 64'(ni_bus.core_ej_flit), 64'(exp_seq[0]));

      // T5: one more double write while full, with a same-cycle pop
      ni_bus.dout_l_1    = with_vld(rand_flit());
      ni_bus.dout_l_2    = with_vld(rand_flit());
      ni_bus.core_ej_rdy = 1;
      step();
      ni_bus.dout_l_1    = '0;
      ni_bus.dout_l_2    = '0;
      ni_bus.core_ej_rdy = 0;
      step();
      check("t5_ovf", 64'(ni_bus.ej_overflow), 64'd1);
`ifdef LOCAL_NI_STATS_EN
      check("t5_drop", 64'(ni_bus.stat_ej_drop), 64'd2);
`endif
      popped.delete();
      ni_bus.core_ej_rdy = 1;
      for (int k = 0; k < 20; k++) begin
         if (ni_bus.core_ej_vld) popped.push_back(ni_bus.core_ej_flit);
         step();
      end
      ni_bus.core_ej_rdy = 0;
      check("t5_remaining", 64'(popped.size()), 64'd7);
      for (int i = 0; i < popped.size() && i < 7; i++)
         check("t5_order", 64'(popped[i]), 64'(exp_seq[i+1]));

      // T6: reset while waiting on a grant with 3 flits queued
      for (int k = 0; k < 3; k++) begin
         ni_bus.core_inj_flit = rand_flit();
         ni_bus.core_inj_vld  = 1;
         step();
      end
      ni_bus.core_inj_vld = 0;
      do_reset_mid();
      offer_cyc.delete();
      for (int k = 0; k < 6; k++) step();
      check("t6_no_offer", 64'(offer_cyc.size()), 64'd0);
      check("t6_ej_empty", 64'(ni_bus.core_ej_vld), 64'd0);
      check("t6_rdy", 64'(ni_bus.core_inj_rdy), 64'd1);

      // Random traffic with random grants, one reset in the middle
      accept_mode = 2;
      for (int k = 0; k < 3000; k++) begin
         if (k == 1500) do_reset_mid();
         ni_bus.core_inj_flit = rand_flit();
         ni_bus.core_inj_vld  = 1'($urandom_range(0, 1));
         f = rand_flit();
         f.vld = ($urandom_range(0, 99) < 30);
         ni_bus.dout_l_1 = f;
         f = rand_flit();
         f.vld = ($urandom_range(0, 99) < 30);
         ni_bus.dout_l_2 = f;
         ni_bus.core_ej_rdy = 1'($urandom_range(0, 1));
         step();
      end

      // Drain everything
      accept_mode = 1;
      idle_inputs();
      ni_bus.core_ej_rdy = 1;
      for (int k = 0; k < 60; k++) step();
      check("drain_din_vld", 64'(ni_bus.rtr_din_l.vld), 64'd0);
      check("drain_ej_vld", 64'(ni_bus.core_ej_vld), 64'd0);
      check("drain_rdy", 64'(ni_bus.core_inj_rdy), 64'd1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
